spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  SPI mode-0 slave. Sits directly downstream of the runner SPI master and consumes its mosi/sclk.
//  - All SPI inputs are oversampled and synchronized into sys_clk.
//  - Each received byte is presented on a parallel port with a one-cycle valid pulse.
//  - A reply byte is returned on miso, MSB first.
//  - The low 6 bits of the last received byte are mirrored onto the board LEDs.
// PARAMETERS
//  REG_WIDTH    8  bits per SPI word; MSB first
//  SYNC_STAGES  2  flops per input synchronizer (>=2)
// PORTS
//  sys_clk   in   1          system clock; only clock in the block
//  rstn      in   1          asynchronous, active-low reset
//  sclk      in   1          SPI clock from master (async to sys_clk)
//  mosi      in   1          master-out data
//  cs_n      in   1          chip select, active low; frames a transfer
//  miso      out  1          slave-out data; 0 whenever cs_n high
//  rx_data   out  REG_WIDTH  last completely received word
//  rx_valid  out  1          1-cycle pulse when rx_data updates
//  tx_data   in   REG_WIDTH  reply word for the next transfer
//  tx_load   in   1          1-cycle strobe: capture tx_data into the tx shadow
//  tx_busy   out  1          high while a word is being shifted
//  frame_err out  1          1-cycle pulse: cs_n rose before word complete
//  led       out  6          rx_data[5:0] of the last valid word
// BEHAVIOUR
//  Reset (rstn low, any time, incl. mid-frame)
//   - All outputs go to 0; tx shadow, shift regs and counter go to 0; state goes to ST_IDLE.
//   - The synchronizer flops reset so that sclk=0, mosi=0, cs_n=1.
//  Input conditioning
//   - sclk, mosi and cs_n pass through SYNC_STAGES flops.
//   - sclk_rise / sclk_fall come from the synced value vs. its previous-cycle value.
//   - Legal sclk frequency is at most sys_clk/4. Faster sclk is out of spec and unchecked.
//  State machine (counter width $clog2(REG_WIDTH)+1)
//   ST_IDLE: cs_n high; miso=0; tx_busy=0. Synced cs_n falling -> ST_LOAD.
//   ST_LOAD (1 cycle):
//    - tx_sr <= tx shadow; miso <= tx shadow[MSB]; count <= 0.
//    - tx_busy <= 1; go to ST_SHIFT.
//   ST_SHIFT:
//    - On sclk_rise: rx_sr <= {rx_sr[REG_WIDTH-2:0], mosi_s}; count <= count+1.
//    - On sclk_fall with count<REG_WIDTH: tx_sr shifts left; miso <= next bit.
//    - When count reaches REG_WIDTH -> ST_DONE.
//   ST_DONE (1 cycle):
//    - rx_data <= rx_sr; led <= rx_sr[5:0]; rx_valid=1.
//    - tx_sr reloads from the tx shadow; count <= 0.
//    - If cs_n still low -> ST_SHIFT: back-to-back word, miso shows new MSB before the next sclk rise.
//    - Otherwise -> ST_IDLE, tx_busy <= 0.
//  Abort: synced cs_n rises in ST_LOAD or ST_SHIFT with count<REG_WIDTH:
//   - frame_err pulses for 1 cycle; go to ST_IDLE.
//   - No rx_valid; rx_data and led keep their old values.
//   - miso -> 0 on the next cycle.
//  tx_load
//   - Updates only the shadow. A word already in flight is never altered.
//   - If tx_load coincides with ST_LOAD or ST_DONE, the new tx_data is the word loaded (bypass).
//  Latency: rx_valid is high exactly SYNC_STAGES+2 sys_clk cycles after the 8th sclk rising edge at the pin.
//  No glitch on miso: it changes only in ST_LOAD, ST_DONE, on sclk_fall, or when leaving for ST_IDLE.
// STRUCTURE
//  Package spi_pkg holds:
//   - ST_IDLE=0, ST_LOAD=1, ST_SHIFT=2, ST_DONE=3 (width 2);
//   - the default REG_WIDTH=8 and LED_WIDTH=6.
//  Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus optional rise/fall detect.
//   - Instantiated for sclk (edges used) and for cs_n (edges used).
//   - Also instantiated for mosi (level only).
//  All remaining logic (FSM, shift regs, outputs) stays in spi_slave_rx.
// TESTING
//  1 Reset: rstn low after 4 sclk rises of a frame -> all outputs 0, state ST_IDLE; next frame received correctly.
//  2 Single word: tx_load 0x3C, then master sends 0xA5 at sys_clk/4 ->
//    - miso bits are 0,0,1,1,1,1,0,0;
//    - rx_data=0xA5 with one rx_valid pulse; led=6'h25.
//  3 Back-to-back: cs_n held low while sending 0x01 then 0xFF, tx shadow=0x81 ->
//    - two rx_valid pulses, rx_data 0x01 then 0xFF;
//    - miso returns 0x81 twice.
//  4 Abort: cs_n raised after 5 bits of 0xF0, prior rx_data=0x12 ->
//    - frame_err pulses once, no rx_valid;
//    - rx_data=0x12 and miso=0 afterwards.
//  5 tx_load mid-word: 0x55 in flight, tx_load 0xC3 at bit 3 ->
//    - current word's miso is still 0x55;
//    - next word's miso is 0xC3.
//  6 Loopback with runner master: 16 random words -> every rx_data matches sent word; latency check on each rx_valid.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state encoding and default widths for the SPI slave receiver.
// Imported by spi_slave_rx and its helpers.
package spi_pkg;

  localparam int DEF_REG_WIDTH = 8;
  localparam int LED_WIDTH     = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one async input, with rise/fall detect on the synced level.
// Latency STAGES cycles to dout; edges are valid in the cycle dout changes. No backpressure.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic rstn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled receive into sys_clk, reply on miso, LED mirror of last word.
// rx_valid fires SYNC_STAGES+2 cycles after the last sclk rise; no backpressure, words are never held.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int REG_WIDTH   = DEF_REG_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 cs_n,
  output logic                 miso,
  output logic [REG_WIDTH-1:0] rx_data,
  output logic                 rx_valid,
  input  logic [REG_WIDTH-1:0] tx_data,
  input  logic                 tx_load,
  output logic                 tx_busy,
  output logic                 frame_err,
  output logic [LED_WIDTH-1:0] led
);

  localparam int             CW       = $clog2(REG_WIDTH) + 1;
  localparam logic [CW-1:0]  CNT_FULL = CW'(REG_WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(REG_WIDTH - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_fall, cs_rise_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .din     (sclk),
    .dout    (sclk_s),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .din     (cs_n),
    .dout    (cs_n_s),
    .rise    (cs_rise_unused),
    .fall    (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .din     (mosi),
    .dout    (mosi_s),
    .rise    (mosi_rise_unused),
    .fall    (mosi_fall_unused)
  );

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [REG_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [REG_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [REG_WIDTH-1:0] shadow_q, shadow_d;
  logic [REG_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 miso_q, miso_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 tx_busy_q, tx_busy_d;
  logic [REG_WIDTH-1:0] shadow_eff;

  // A tx_load landing on the load cycle itself must win over the stale shadow.
  assign shadow_eff = tx_load ? tx_data : shadow_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    shadow_d    = shadow_eff;
    rx_data_d   = rx_data_q;
    led_d       = led_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    tx_busy_d   = tx_busy_q;

    unique case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        tx_busy_d = 1'b0;
        count_d   = '0;
        if (cs_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cs_n_s) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          tx_busy_d   = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          tx_sr_d   = shadow_eff;
          miso_d    = shadow_eff[REG_WIDTH-1];
          count_d   = '0;
          tx_busy_d = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_n_s) begin
          // cs_n rising between back-to-back words (count 0) is a clean end of frame.
          frame_err_d = (count_q != '0);
          miso_d      = 1'b0;
          tx_busy_d   = 1'b0;
          state_d     = ST_IDLE;
        end else if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[REG_WIDTH-2:0], mosi_s};
          count_d = count_q + 1'b1;
          if (count_q == CNT_LAST) state_d = ST_DONE;
        end else if (sclk_fall && count_q != '0 && count_q < CNT_FULL) begin
          // count 0 skips the trailing fall of the previous word after a reload.
          tx_sr_d = {tx_sr_q[REG_WIDTH-2:0], 1'b0};
          miso_d  = tx_sr_q[REG_WIDTH-2];
        end
      end
      ST_DONE: begin
        rx_data_d  = rx_sr_q;
        led_d      = rx_sr_q[LED_WIDTH-1:0];
        rx_valid_d = 1'b1;
        tx_sr_d    = shadow_eff;
        count_d    = '0;
        if (!cs_n_s) begin
          miso_d  = shadow_eff[REG_WIDTH-1];
          state_d = ST_SHIFT;
        end else begin
          miso_d    = 1'b0;
          tx_busy_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      shadow_q    <= '0;
      rx_data_q   <= '0;
      led_q       <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      shadow_q    <= shadow_d;
      rx_data_q   <= rx_data_d;
      led_q       <= led_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  assign miso      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_busy   = tx_busy_q;
  assign frame_err = frame_err_q;
  assign led       = led_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: a mode-0 master at sys_clk/4 drives frames, expected words
// are queued at send time and popped on each rx_valid along with the sclk-rise timestamp.
module tb_spi_slave_rx;
  import spi_pkg::*;

  localparam int SYNC = 2;

  logic       sys_clk = 1'b0;
  logic       rstn, sclk, mosi, cs_n, tx_load;
  logic [7:0] tx_data;
  logic       miso, rx_valid, tx_busy, frame_err;
  logic [7:0] rx_data;
  logic [5:0] led;

  spi_slave_rx #(.REG_WIDTH(8), .SYNC_STAGES(SYNC)) dut (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .miso      (miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_busy   (tx_busy),
    .frame_err (frame_err),
    .led       (led)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int         rise_q[$];
  int         vld_cnt  = 0;
  int         ferr_cnt = 0;
  logic [7:0] mon_d;
  int         mon_r;

  always @(posedge sys_clk) begin
    #1;
    if (rstn && rx_valid) begin
      vld_cnt++;
      if (exp_q.size() == 0 || rise_q.size() == 0) begin
        chk("unexpected_rx_valid", 32'd1, 32'd0);
      end else begin
        mon_d = exp_q.pop_front();
        mon_r = rise_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(mon_d));
        chk("led", 32'(led), 32'(mon_d[5:0]));
        chk("latency", 32'(cyc - mon_r), 32'(SYNC + 2));
      end
    end
    if (rstn && frame_err) ferr_cnt++;
  end

  task automatic load(input logic [7:0] v);
    @(negedge sys_clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge sys_clk);
    tx_load = 1'b0;
  endtask

  // Mode 0 at sys_clk/4; miso is sampled just before each falling edge.
  task automatic xfer(input logic [7:0] d, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[7-i];
      repeat (2) @(negedge sys_clk);
      sclk = 1'b1;
      if (i == 7) rise_q.push_back(cyc);
      repeat (2) @(negedge sys_clk);
      r[7-i] = miso;
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input bit do_load, input logic [7:0] txw, input logic [7:0] d,
                       output logic [7:0] r);
    if (do_load) load(txw);
    cs_n = 1'b0;
    repeat (6) @(negedge sys_clk);
    exp_q.push_back(d);
    xfer(d, 8, r);
    repeat (2) @(negedge sys_clk);
    cs_n = 1'b1;
    repeat (10) @(negedge sys_clk);
  endtask

  logic [7:0] r1, r2, rd, rt;
  int         v0, f0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; tx_load = 1'b0; tx_data = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_tx_busy", 32'(tx_busy), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    rstn = 1'b1;
    repeat (4) @(negedge sys_clk);

    // Single word
    v0 = vld_cnt;
    frame(1'b1, 8'h3C, 8'hA5, r1);
    chk("t2_miso", 32'(r1), 32'h3C);
    chk("t2_vld_cnt", 32'(vld_cnt - v0), 32'd1);
    chk("t2_led", 32'(led), 32'h25);

    // Reset mid-frame after 4 rises
    load(8'h77);
    cs_n = 1'b0;
    repeat (6) @(negedge sys_clk);
    xfer(8'hC6, 4, r1);
    chk("t1_busy_before_rst", 32'(tx_busy), 32'h1);
    rstn = 1'b0;
    @(negedge sys_clk);
    chk("t1_rx_data", 32'(rx_data), 32'h0);
    chk("t1_led", 32'(led), 32'h0);
    chk("t1_miso", 32'(miso), 32'h0);
    chk("t1_tx_busy", 32'(tx_busy), 32'h0);
    chk("t1_state", 32'(dut.state_q), 32'(ST_IDLE));
    cs_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    rstn = 1'b1;
    repeat (4) @(negedge sys_clk);
    frame(1'b1, 8'h5A, 8'h96, r1);
    chk("t1_after_miso", 32'(r1), 32'h5A);

    // Back-to-back words in one frame
    v0 = vld_cnt; f0 = ferr_cnt;
    load(8'h81);
    cs_n = 1'b0;
    repeat (6) @(negedge sys_clk);
    exp_q.push_back(8'h01);
    xfer(8'h01, 8, r1);
    exp_q.push_back(8'hFF);
    xfer(8'hFF, 8, r2);
    repeat (2) @(negedge sys_clk);
    cs_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    chk("t3_miso0", 32'(r1), 32'h81);
    chk("t3_miso1", 32'(r2), 32'h81);
    chk("t3_vld_cnt", 32'(vld_cnt - v0), 32'd2);
    chk("t3_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);

    // Abort after 5 bits
    frame(1'b1, 8'h00, 8'h12, r1);
    v0 = vld_cnt; f0 = ferr_cnt;
    cs_n = 1'b0;
    repeat (6) @(negedge sys_clk);
    xfer(8'hF0, 5, r1);
    repeat (2) @(negedge sys_clk);
    cs_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    chk("t4_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
    chk("t4_vld_cnt", 32'(vld_cnt - v0), 32'd0);
    chk("t4_rx_data", 32'(rx_data), 32'h12);
    chk("t4_led", 32'(led), 32'h12);
    chk("t4_miso", 32'(miso), 32'h0);
    chk("t4_tx_busy", 32'(tx_busy), 32'h0);

    // tx_load while a word is in flight
    load(8'h55);
    cs_n = 1'b0;
    repeat (6) @(negedge sys_clk);
    exp_q.push_back(8'h3E);
    fork
      xfer(8'h3E, 8, r1);
      begin
        repeat (14) @(negedge sys_clk);
        chk("t5_busy", 32'(tx_busy), 32'h1);
        tx_data = 8'hC3;
        tx_load = 1'b1;
        @(negedge sys_clk);
        tx_load = 1'b0;
        tx_data = 8'h00;
      end
    join
    repeat (2) @(negedge sys_clk);
    cs_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    chk("t5_cur_miso", 32'(r1), 32'h55);
    frame(1'b0, 8'h00, 8'h6B, r2);
    chk("t5_next_miso", 32'(r2), 32'hC3);

    // Random loopback
    v0 = vld_cnt;
    for (int k = 0; k < 16; k++) begin
      rd = 8'($urandom_range(0, 255));
      rt = 8'($urandom_range(0, 255));
      frame(1'b1, rt, rd, r1);
      chk("t6_miso", 32'(r1), 32'(rt));
    end
    chk("t6_vld_cnt", 32'(vld_cnt - v0), 32'd16);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
